sha_round_sequencer: RTL and testbench
======================================

Name: sha_round_sequencer

Overview:
- Control FSM for the double SHA-256 mining datapath: message-schedule unit, round core, and H0..H7 accumulators.
- Drives the phase code, round index and strobes that step the datapath through three 64-round chunks:
  - chunk 1: header bytes 0-63;
  - chunk 2: header tail plus nonce;
  - chunk 3: second hash.
- Caches the chunk-1 midstate after the first nonce, sweeps a nonce range, and reports a hit from the target comparator.

Parameters:
ROUNDS, 64, rounds per chunk; round index is 6 bits wide.
NONCE_W, 32, nonce width.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; accepted only in IDLE
abort  in  1  cancel the sweep from any state
nonce_first  in  NONCE_W  first nonce; sampled on an accepted start
nonce_last  in  NONCE_W  last nonce, inclusive; sampled on an accepted start
hit  in  1  comparator result; valid only while check=1
busy  out  1  high in every state except IDLE and DONE
block  out  2  phase code to accumulators: 0 init, 1 chunk1, 2 chunk2, 3 chunk3
nonce_sig  out  1  0 on the first nonce of a sweep; 1 once the midstate is cached
round  out  6  current round index
load_w  out  1  one-cycle pulse: load message words for the chunk
round_en  out  1  advance the round core one round
accum  out  1  one-cycle pulse: accumulators add the working vars
check  out  1  one-cycle pulse: comparator output is sampled
nonce  out  NONCE_W  nonce currently in the datapath
found  out  1  sweep ended on a hit; holds until the next start
exhausted  out  1  sweep ended without a hit; holds until the next start

Behaviour:
- Reset / values in IDLE:
  - all outputs 0, block=0, nonce_sig=0, state IDLE;
  - block=0 with nonce_sig=0 reinitialises the accumulators to the IV.
- States: IDLE, LOAD, ROUNDS, ACCUM, CHECK, DONE.
- IDLE + start:
  - latch the range, nonce<=nonce_first, block<=1, nonce_sig<=0, clear found/exhausted;
  - go to LOAD.
- LOAD (1 cycle): load_w=1, round<=0; go to ROUNDS.
- ROUNDS (ROUNDS cycles):
  - round_en=1 each cycle, round increments by 1;
  - at round=ROUNDS-1, go to ACCUM.
- ACCUM (1 cycle): accum=1, then:
  - block=1: block<=2, go to LOAD;
  - block=2: block<=3, go to LOAD;
  - block=3: go to CHECK.
- CHECK (1 cycle), check=1:
  - hit=1: found<=1, go to DONE; nonce holds the winning value.
  - else if nonce==nonce_last: exhausted<=1, go to DONE.
  - else: nonce<=nonce+1 (mod 2^NONCE_W), nonce_sig<=1, block<=2, go to LOAD. Chunk 1 is skipped.
- DONE:
  - block, nonce and flags hold;
  - start re-arms exactly as from IDLE, with nonce_sig<=0 and block<=1.
- Latency, LOAD to ACCUM inclusive:
  - chunk = ROUNDS+2 cycles;
  - first nonce = 3*(ROUNDS+2)+1 = 199 cycles;
  - each later nonce = 2*(ROUNDS+2)+1 = 133 cycles.
- block and nonce_sig are stable from LOAD through ACCUM of a chunk. They change only on the cycle after ACCUM or CHECK.
- Wrap-around: nonce_first > nonce_last is legal. The sweep passes 2^NONCE_W-1, wraps to 0, and stops at nonce_last.
- Single-nonce sweep: nonce_first == nonce_last evaluates exactly one nonce.
- Simultaneous hit and nonce==nonce_last: found wins, exhausted stays 0.
- abort:
  - highest priority in every state, including a cycle that has start=1;
  - next state IDLE, block=0, nonce_sig=0, all strobes 0, found/exhausted cleared.
- start outside IDLE/DONE is ignored.
- reset_n asserted mid-sweep: immediate return to reset values, no pending strobe completes.

Optional Feature:
- Macro: SHA_SEQ_HASH_CNT_EN.
- Defined:
  - adds output hash_cnt [31:0], counting completed nonce evaluations (+1 per CHECK cycle);
  - cleared on reset and on an accepted start; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package sha_mine_pkg holds:
  - phase encoding constants PH_INIT=0, PH_CHUNK1=1, PH_CHUNK2=2, PH_CHUNK3=3;
  - the FSM state enum;
  - ROUNDS_DEFAULT=64 and the SHA-256 IV constants used by the accumulators.
- One natural sub-module: nonce_range_counter, which handles the latch, increment, wrap and last-compare and provides an is_last output.

Test Plan:
- Reset then start, nonce_first=0x10, nonce_last=0x10, hit=0 always:
  - block sequence 1,2,3;
  - exactly 3 load_w, 3 accum, 1 check;
  - exhausted=1 at cycle 199 after start, nonce=0x10.
- Range 0x0..0x2, hit=1 on the check of nonce 0x1:
  - second nonce starts at block=2 with nonce_sig=1;
  - found=1, nonce=0x1, 199+133 cycles.
- Wrap range nonce_first=0xFFFFFFFE, nonce_last=0x00000001, hit=0:
  - nonces checked 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1;
  - then exhausted=1.
- abort asserted at round=30 of chunk 2:
  - next cycle block=0, nonce_sig=0, busy=0, no accum pulse;
  - a fresh start restarts at block=1.
- hit=1 on the check of nonce_last=0x5: found=1, exhausted=0.
- reset_n pulsed low mid-ROUNDS: outputs go to reset values without waiting for a clock edge; start is again accepted afterwards.

Source files
------------

// File: rtl/sha_mine_pkg.sv
// rtl/sha_mine_pkg.sv - shared constants, FSM state enum and IV helper for the SHA-256 mining datapath
package sha_mine_pkg;

    localparam int ROUNDS_DEFAULT = 64;

    localparam logic [1:0] PH_INIT   = 2'd0;
    localparam logic [1:0] PH_CHUNK1 = 2'd1;
    localparam logic [1:0] PH_CHUNK2 = 2'd2;
    localparam logic [1:0] PH_CHUNK3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUNDS = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // SHA-256 initial hash value H0..H7, loaded by the accumulators in phase PH_INIT
    function automatic logic [31:0] sha256_iv(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0:    v = 32'h6a09e667;
            3'd1:    v = 32'hbb67ae85;
            3'd2:    v = 32'h3c6ef372;
            3'd3:    v = 32'ha54ff53a;
            3'd4:    v = 32'h510e527f;
            3'd5:    v = 32'h9b05688c;
            3'd6:    v = 32'h1f83d9ab;
            default: v = 32'h5be0cd19;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sha_round_sequencer_if.sv
// rtl/sha_round_sequencer_if.sv - sweep control and datapath strobe bundle; hash_cnt present under SHA_SEQ_HASH_CNT_EN
interface sha_round_sequencer_if #(
    parameter int NONCE_W = 32
) ();
    logic               start;
    logic               abort;
    logic [NONCE_W-1:0] nonce_first;
    logic [NONCE_W-1:0] nonce_last;
    logic               hit;
    logic               busy;
    logic [1:0]         block;
    logic               nonce_sig;
    logic [5:0]         round;
    logic               load_w;
    logic               round_en;
    logic               accum;
    logic               check;
    logic [NONCE_W-1:0] nonce;
    logic               found;
    logic               exhausted;
`ifdef SHA_SEQ_HASH_CNT_EN
    logic [31:0]        hash_cnt;
`endif

    modport master (
        output start, abort, nonce_first, nonce_last, hit,
        input  busy, block, nonce_sig, round, load_w, round_en, accum, check,
               nonce, found, exhausted
`ifdef SHA_SEQ_HASH_CNT_EN
        , input hash_cnt
`endif
    );

    modport slave (
        input  start, abort, nonce_first, nonce_last, hit,
        output busy, block, nonce_sig, round, load_w, round_en, accum, check,
               nonce, found, exhausted
`ifdef SHA_SEQ_HASH_CNT_EN
        , output hash_cnt
`endif
    );
endinterface

// File: rtl/nonce_range_counter.sv
// rtl/nonce_range_counter.sv - latches the nonce range, steps the nonce with wrap, flags the last nonce
module nonce_range_counter #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               inc,
    input  logic [NONCE_W-1:0] first,
    input  logic [NONCE_W-1:0] last,
    output logic [NONCE_W-1:0] nonce,
    output logic               is_last
);
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] last_q, last_d;

    // clear beats load beats increment; increment wraps naturally mod 2^NONCE_W
    always_comb begin
        nonce_d = nonce_q;
        last_d  = last_q;
        if (clr) begin
            nonce_d = '0;
            last_d  = '0;
        end else if (load) begin
            nonce_d = first;
            last_d  = last;
        end else if (inc) begin
            nonce_d = nonce_q + NONCE_W'(1);
        end
    end

    // range registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q <= '0;
            last_q  <= '0;
        end else begin
            nonce_q <= nonce_d;
            last_q  <= last_d;
        end
    end

    assign nonce   = nonce_q;
    assign is_last = (nonce_q == last_q);
endmodule

// File: rtl/sha_round_sequencer.sv
// rtl/sha_round_sequencer.sv - double SHA-256 round sequencer FSM with nonce sweep; SHA_SEQ_HASH_CNT_EN adds hash_cnt
module sha_round_sequencer
    import sha_mine_pkg::*;
#(
    parameter int ROUNDS  = ROUNDS_DEFAULT,
    parameter int NONCE_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sha_round_sequencer_if.slave  bus
);
    localparam logic [5:0] ROUND_LAST = 6'(ROUNDS - 1);

    seq_state_e         state_q, state_d;
    logic [1:0]         block_q, block_d;
    logic               nonce_sig_q, nonce_sig_d;
    logic [5:0]         round_q, round_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               cnt_clr, cnt_load, cnt_inc;
    logic [NONCE_W-1:0] cur_nonce;
    logic               is_last;

    nonce_range_counter #(.NONCE_W(NONCE_W)) u_nonce (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr     (cnt_clr),
        .load    (cnt_load),
        .inc     (cnt_inc),
        .first   (bus.nonce_first),
        .last    (bus.nonce_last),
        .nonce   (cur_nonce),
        .is_last (is_last)
    );

    // next-state and register updates; abort overrides everything, including a start
    always_comb begin
        state_d     = state_q;
        block_d     = block_q;
        nonce_sig_d = nonce_sig_q;
        round_d     = round_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        cnt_clr     = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        if (bus.abort) begin
            state_d     = ST_IDLE;
            block_d     = PH_INIT;
            nonce_sig_d = 1'b0;
            round_d     = '0;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            cnt_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_d     = ST_LOAD;
                        block_d     = PH_CHUNK1;
                        nonce_sig_d = 1'b0;
                        round_d     = '0;
                        found_d     = 1'b0;
                        exhausted_d = 1'b0;
                        cnt_load    = 1'b1;
                    end
                end
                ST_LOAD: begin
                    round_d = '0;
                    state_d = ST_ROUNDS;
                end
                ST_ROUNDS: begin
                    round_d = round_q + 6'd1;
                    if (round_q == ROUND_LAST) begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    case (block_q)
                        PH_CHUNK1: begin
                            block_d = PH_CHUNK2;
                            state_d = ST_LOAD;
                        end
                        PH_CHUNK2: begin
                            block_d = PH_CHUNK3;
                            state_d = ST_LOAD;
                        end
                        default: state_d = ST_CHECK;
                    endcase
                end
                ST_CHECK: begin
                    if (bus.hit) begin
                        found_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (is_last) begin
                        exhausted_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        // midstate is cached now, so later nonces start at chunk 2
                        cnt_inc     = 1'b1;
                        nonce_sig_d = 1'b1;
                        block_d     = PH_CHUNK2;
                        state_d     = ST_LOAD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // sequencer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            block_q     <= PH_INIT;
            nonce_sig_q <= 1'b0;
            round_q     <= '0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            nonce_sig_q <= nonce_sig_d;
            round_q     <= round_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.block     = block_q;
    assign bus.nonce_sig = nonce_sig_q;
    assign bus.round     = round_q;
    assign bus.load_w    = (state_q == ST_LOAD);
    assign bus.round_en  = (state_q == ST_ROUNDS);
    assign bus.accum     = (state_q == ST_ACCUM);
    assign bus.check     = (state_q == ST_CHECK);
    assign bus.nonce     = cur_nonce;
    assign bus.found     = found_q;
    assign bus.exhausted = exhausted_q;

`ifdef SHA_SEQ_HASH_CNT_EN
    logic [31:0] hash_cnt_q, hash_cnt_d;
    logic        start_acc;

    assign start_acc = !bus.abort && bus.start &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // saturating count of completed nonce evaluations, restarted by each accepted start
    always_comb begin
        hash_cnt_d = hash_cnt_q;
        if (start_acc) begin
            hash_cnt_d = '0;
        end else if (!bus.abort && (state_q == ST_CHECK) && (hash_cnt_q != 32'hFFFF_FFFF)) begin
            hash_cnt_d = hash_cnt_q + 32'd1;
        end
    end

    // evaluation counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hash_cnt_q <= '0;
        end else begin
            hash_cnt_q <= hash_cnt_d;
        end
    end

    assign bus.hash_cnt = hash_cnt_q;
`endif
endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb/tb_sha_round_sequencer.sv - directed self-checking bench for sha_round_sequencer
module tb_sha_round_sequencer;
    logic clk;
    logic reset_n;

    sha_round_sequencer_if #(.NONCE_W(32)) bus ();

    sha_round_sequencer #(.ROUNDS(64), .NONCE_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          n_load;
    int          n_accum;
    int          n_check;
    int          first_chk;
    int          last_chk;
    logic [15:0] blk_seq;
    logic [7:0]  sig_seq;
    logic [31:0] chk_n [0:7];
    logic        hit_armed;
    logic [31:0] hit_nonce;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        cyc       = 0;
        n_load    = 0;
        n_accum   = 0;
        n_check   = 0;
        first_chk = -1;
        last_chk  = -1;
        blk_seq   = '0;
        sig_seq   = '0;
        for (int i = 0; i < 8; i++) chk_n[i] = '0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.load_w === 1'b1) begin
            blk_seq = {blk_seq[13:0], bus.block};
            sig_seq = {sig_seq[6:0], bus.nonce_sig};
            n_load++;
        end
        if (bus.accum === 1'b1) n_accum++;
        if (bus.check === 1'b1) begin
            if (n_check < 8) chk_n[n_check] = bus.nonce;
            n_check++;
            if (first_chk < 0) first_chk = cyc;
            last_chk = cyc;
        end
        bus.hit = (bus.check === 1'b1) && hit_armed && (bus.nonce == hit_nonce);
    endtask

    task automatic begin_sweep(input logic [31:0] f, input logic [31:0] l,
                               input logic armed, input logic [31:0] hn);
        clear_log();
        hit_armed       = armed;
        hit_nonce       = hn;
        bus.nonce_first = f;
        bus.nonce_last  = l;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    task automatic finish_sweep(input int budget);
        while ((bus.busy === 1'b1) && (cyc < budget)) step();
    endtask

    initial begin
        int snap;
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.hit = 1'b0;
        bus.nonce_first = '0;
        bus.nonce_last = '0;
        hit_armed = 1'b0;
        hit_nonce = '0;
        clear_log();
        repeat (3) @(negedge clk);

        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_block", 64'(bus.block), 64'd0);
        chk("rst_sig",   64'(bus.nonce_sig), 64'd0);
        chk("rst_strb",  64'({bus.load_w, bus.round_en, bus.accum, bus.check}), 64'd0);
        chk("rst_flags", 64'({bus.found, bus.exhausted}), 64'd0);
        chk("rst_nonce", 64'(bus.nonce), 64'd0);
        reset_n = 1'b1;
        step();

        // single-nonce sweep, never hits
        begin_sweep(32'h10, 32'h10, 1'b0, 32'h0);
        chk("t1_load_blk", 64'(bus.block), 64'd1);
        finish_sweep(1000);
        chk("t1_done",      64'(bus.busy), 64'd0);
        chk("t1_blk_seq",   64'(blk_seq), 64'h1B);
        chk("t1_n_load",    64'(n_load), 64'd3);
        chk("t1_n_accum",   64'(n_accum), 64'd3);
        chk("t1_n_check",   64'(n_check), 64'd1);
        chk("t1_check_cyc", 64'(first_chk), 64'd199);
        chk("t1_exhausted", 64'(bus.exhausted), 64'd1);
        chk("t1_found",     64'(bus.found), 64'd0);
        chk("t1_nonce",     64'(bus.nonce), 64'h10);
        step();
        chk("t1_hold_blk",  64'(bus.block), 64'd3);

        // range 0..2, hit on nonce 1 (re-armed straight from DONE)
        begin_sweep(32'h0, 32'h2, 1'b1, 32'h1);
        chk("t2_flags_clr", 64'({bus.found, bus.exhausted}), 64'd0);
        finish_sweep(1000);
        chk("t2_blk_seq",   64'(blk_seq), 64'h1BB);
        chk("t2_sig_seq",   64'(sig_seq), 64'h03);
        chk("t2_n_check",   64'(n_check), 64'd2);
        chk("t2_hit_cyc",   64'(last_chk), 64'd332);
        chk("t2_found",     64'(bus.found), 64'd1);
        chk("t2_exhausted", 64'(bus.exhausted), 64'd0);
        chk("t2_nonce",     64'(bus.nonce), 64'h1);

        // wrap-around sweep
        begin_sweep(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'h0);
        finish_sweep(2000);
        chk("t3_n_check",   64'(n_check), 64'd4);
        chk("t3_nonce0",    64'(chk_n[0]), 64'hFFFF_FFFE);
        chk("t3_nonce1",    64'(chk_n[1]), 64'hFFFF_FFFF);
        chk("t3_nonce2",    64'(chk_n[2]), 64'h0);
        chk("t3_nonce3",    64'(chk_n[3]), 64'h1);
        chk("t3_last_cyc",  64'(last_chk), 64'd598);
        chk("t3_exhausted", 64'(bus.exhausted), 64'd1);
        chk("t3_nonce_end", 64'(bus.nonce), 64'h1);

        // abort at round 30 of chunk 2
        begin_sweep(32'h0, 32'h5, 1'b0, 32'h0);
        while (!((bus.block == 2'd2) && (bus.round_en === 1'b1) && (bus.round == 6'd30)) && (cyc < 500)) step();
        chk("t4_reach_r30", 64'({bus.block, bus.round}), 64'({2'd2, 6'd30}));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t4_block",  64'(bus.block), 64'd0);
        chk("t4_sig",    64'(bus.nonce_sig), 64'd0);
        chk("t4_busy",   64'(bus.busy), 64'd0);
        chk("t4_strb",   64'({bus.load_w, bus.round_en, bus.accum, bus.check}), 64'd0);
        snap = n_accum;
        repeat (40) step();
        chk("t4_no_accum", 64'(n_accum), 64'(snap));
        bus.start = 1'b1;
        bus.nonce_first = 32'h0;
        bus.nonce_last = 32'h5;
        step();
        bus.start = 1'b0;
        chk("t4_restart", 64'({bus.block, bus.load_w, bus.nonce_sig}), 64'({2'd1, 1'b1, 1'b0}));
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("t4_abort_prio", 64'({bus.busy, bus.block}), 64'd0);

        // hit coincides with last nonce
        begin_sweep(32'h3, 32'h5, 1'b1, 32'h5);
        finish_sweep(1000);
        chk("t5_n_check",   64'(n_check), 64'd3);
        chk("t5_found",     64'(bus.found), 64'd1);
        chk("t5_exhausted", 64'(bus.exhausted), 64'd0);
        chk("t5_nonce",     64'(bus.nonce), 64'h5);

        // asynchronous reset in the middle of the rounds
        begin_sweep(32'h7, 32'h9, 1'b0, 32'h0);
        while (!((bus.round_en === 1'b1) && (bus.round == 6'd10)) && (cyc < 200)) step();
        chk("t6_reach_r10", 64'(bus.round), 64'd10);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_busy",  64'(bus.busy), 64'd0);
        chk("t6_block", 64'(bus.block), 64'd0);
        chk("t6_round", 64'(bus.round), 64'd0);
        chk("t6_strb",  64'({bus.load_w, bus.round_en, bus.accum, bus.check}), 64'd0);
        chk("t6_nonce", 64'(bus.nonce), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        begin_sweep(32'h7, 32'h7, 1'b0, 32'h0);
        chk("t6_restart", 64'({bus.block, bus.load_w, bus.busy}), 64'({2'd1, 1'b1, 1'b1}));
        finish_sweep(1000);
        chk("t6_nonce_end", 64'({bus.exhausted, bus.nonce}), 64'({1'b1, 32'h7}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
